trap_ctrl: RTL and testbench

- Machine-mode trap controller, directly upstream of the CSR unit.
- Collects synchronous exceptions from the pipeline and the external/timer/software interrupt lines, and arbitrates them by priority.
- On a trap it redirects fetch, flushes the pipeline and issues one-cycle update strobes for mepc, mcause, mtval and mstatus into the CSR unit.
- Also sequences MRET: restores mstatus.MIE and returns to mepc.

---
 rtl/trap_ctrl_pkg.sv | 40 ++++
 rtl/trap_ctrl_irq_sync.sv | 31 +++
 rtl/trap_ctrl.sv | 163 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap controller: cause codes, mtvec modes,
// FSM encoding and the trap-vector helper.
package trap_ctrl_pkg;

  localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] EXC_INSTR_ACCESS     = 4'd1;
  localparam logic [3:0] EXC_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT       = 4'd3;
  localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] EXC_LOAD_ACCESS      = 4'd5;
  localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] EXC_STORE_ACCESS     = 4'd7;
  localparam logic [3:0] EXC_ECALL_M          = 4'd11;

  localparam logic [3:0] INT_MSI = 4'd3;
  localparam logic [3:0] INT_MTI = 4'd7;
  localparam logic [3:0] INT_MEI = 4'd11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  typedef enum logic [1:0] {
    StIdle,
    StTrap,
    StMret,
    StWaitAck
  } trap_state_e;

  // Only interrupts use the vectored offset; modes 2 and 3 fall back to direct.
  function automatic logic [31:0] trap_target(logic [31:0] mtvec, logic is_irq,
                                              logic [3:0] code);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (is_irq && (mtvec[1:0] == MTVEC_VECTORED)) begin
      return base + {26'd0, code, 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Two-flop level synchronizer for one interrupt line; Enable=0 passes the input through.
module trap_ctrl_irq_sync #(
  parameter bit Enable = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  if (Enable) begin : g_sync
    logic meta_q, sync_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        meta_q <= 1'b0;
        sync_q <= 1'b0;
      end else begin
        meta_q <= d_i;
        sync_q <= meta_q;
      end
    end

    assign q_o = sync_q;
  end else begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign q_o = d_i;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions and interrupts at the commit boundary,
// redirects fetch and strobes the CSR unit for trap entry and MRET.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter bit          SYNC_IRQ = 1'b1,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        irq_meip_i,
  input  logic        irq_mtip_i,
  input  logic        irq_msip_i,
  input  logic        mstatus_mie_i,
  input  logic        mstatus_mpie_i,
  input  logic [2:0]  mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] pc_i,
  input  logic        commit_valid_i,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_cause_i,
  input  logic [31:0] exc_tval_i,
  input  logic        mret_i,
  input  logic        redirect_ack_i,
  output logic        redirect_o,
  output logic [31:0] trap_pc_o,
  output logic        csr_trap_we_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o,
  output logic [31:0] csr_mtval_o,
  output logic        csr_mret_we_o,
  output logic [2:0]  mip_o,
  output logic        busy_o
);

  trap_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  logic [2:0]  irq_raw, irq_sync;
  logic [2:0]  int_pend;
  logic        is_irq;
  logic [3:0]  code;
  logic [31:0] mret_pc;
  logic        redirect, trap_we, mret_we;
  logic [31:0] trap_pc;

  // MPIE restore is performed by the CSR unit itself; mepc[0] is never a valid target bit.
  logic unused_in;
  assign unused_in = mstatus_mpie_i ^ mepc_i[0];

  assign irq_raw = {irq_meip_i, irq_mtip_i, irq_msip_i};

  for (genvar i = 0; i < 3; i++) begin : g_irq
    trap_ctrl_irq_sync #(
      .Enable(SYNC_IRQ)
    ) u_sync (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .d_i  (irq_raw[i]),
      .q_o  (irq_sync[i])
    );
  end

  assign mip_o    = rst_i ? 3'b000 : irq_sync;
  assign int_pend = mip_o & mie_i & {3{mstatus_mie_i}};
  assign mret_pc  = {mepc_i[31:1], 1'b0};

  // Cause selection: exception, then MEI > MSI > MTI.
  always_comb begin
    is_irq = 1'b0;
    code   = 4'd0;
    if (exc_valid_i) begin
      code = exc_cause_i;
    end else if (int_pend[2]) begin
      is_irq = 1'b1;
      code   = INT_MEI;
    end else if (int_pend[0]) begin
      is_irq = 1'b1;
      code   = INT_MSI;
    end else if (int_pend[1]) begin
      is_irq = 1'b1;
      code   = INT_MTI;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    redirect = 1'b0;
    trap_we  = 1'b0;
    mret_we  = 1'b0;
    trap_pc  = pc_q;

    unique case (state_q)
      StIdle: begin
        if (commit_valid_i) begin
          if (exc_valid_i || (int_pend != 3'b000)) begin
            state_d  = StTrap;
            pc_d     = trap_target(mtvec_i, is_irq, code);
            mepc_d   = pc_i;
            mcause_d = {is_irq, 27'd0, code};
            mtval_d  = is_irq ? 32'd0 : exc_tval_i;
          end else if (mret_i) begin
            state_d = StMret;
          end
        end
      end
      StTrap: begin
        trap_we  = 1'b1;
        redirect = 1'b1;
        state_d  = redirect_ack_i ? StIdle : StWaitAck;
      end
      StMret: begin
        mret_we  = 1'b1;
        redirect = 1'b1;
        trap_pc  = mret_pc;
        pc_d     = mret_pc;
        state_d  = redirect_ack_i ? StIdle : StWaitAck;
      end
      StWaitAck: begin
        redirect = 1'b1;
        if (redirect_ack_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      mepc_q   <= 32'd0;
      mcause_q <= 32'd0;
      mtval_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
    end
  end

  // Outputs are forced to their reset values for as long as reset is held.
  assign redirect_o    = redirect & ~rst_i;
  assign csr_trap_we_o = trap_we & ~rst_i;
  assign csr_mret_we_o = mret_we & ~rst_i;
  assign trap_pc_o     = rst_i ? RESET_PC : trap_pc;
  assign csr_mepc_o    = rst_i ? 32'd0 : mepc_q;
  assign csr_mcause_o  = rst_i ? 32'd0 : mcause_q;
  assign csr_mtval_o   = rst_i ? 32'd0 : mtval_q;
  assign busy_o        = ~rst_i & (state_q != StIdle);

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes expected CSR/redirect transactions,
// a negedge monitor pops and checks them whenever a strobe appears.
module tb_trap_ctrl;

  localparam logic [31:0] RstPc = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        irq_meip_i, irq_mtip_i, irq_msip_i;
  logic        mstatus_mie_i, mstatus_mpie_i;
  logic [2:0]  mie_i;
  logic [31:0] mtvec_i, mepc_i, pc_i, exc_tval_i;
  logic        commit_valid_i, exc_valid_i, mret_i, redirect_ack_i;
  logic [3:0]  exc_cause_i;
  logic        redirect_o, csr_trap_we_o, csr_mret_we_o, busy_o;
  logic [31:0] trap_pc_o, csr_mepc_o, csr_mcause_o, csr_mtval_o;
  logic [2:0]  mip_o;

  trap_ctrl #(
    .SYNC_IRQ(1'b1),
    .RESET_PC(RstPc)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .irq_meip_i    (irq_meip_i),
    .irq_mtip_i    (irq_mtip_i),
    .irq_msip_i    (irq_msip_i),
    .mstatus_mie_i (mstatus_mie_i),
    .mstatus_mpie_i(mstatus_mpie_i),
    .mie_i         (mie_i),
    .mtvec_i       (mtvec_i),
    .mepc_i        (mepc_i),
    .pc_i          (pc_i),
    .commit_valid_i(commit_valid_i),
    .exc_valid_i   (exc_valid_i),
    .exc_cause_i   (exc_cause_i),
    .exc_tval_i    (exc_tval_i),
    .mret_i        (mret_i),
    .redirect_ack_i(redirect_ack_i),
    .redirect_o    (redirect_o),
    .trap_pc_o     (trap_pc_o),
    .csr_trap_we_o (csr_trap_we_o),
    .csr_mepc_o    (csr_mepc_o),
    .csr_mcause_o  (csr_mcause_o),
    .csr_mtval_o   (csr_mtval_o),
    .csr_mret_we_o (csr_mret_we_o),
    .mip_o         (mip_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_mret;
    logic [31:0] pc;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_trap   = 0;
  int   n_mret   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic is_mret, input logic [31:0] pc, input logic [31:0] mepc,
                      input logic [31:0] mcause, input logic [31:0] mtval);
    exp_t e;
    e.is_mret = is_mret;
    e.pc      = pc;
    e.mepc    = mepc;
    e.mcause  = mcause;
    e.mtval   = mtval;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k;
    k = 0;
    @(negedge clk);
    while (busy_o && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'd0, busy_o}, 32'd0);
  endtask

  // Monitor: every strobe must match the oldest expected transaction.
  always @(negedge clk) begin
    if (csr_trap_we_o || csr_mret_we_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got trap_we=%0b mret_we=%0b, expected none",
                 csr_trap_we_o, csr_mret_we_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_kind", {31'd0, csr_mret_we_o}, {31'd0, e.is_mret});
        chk("single_strobe", {31'd0, csr_trap_we_o & csr_mret_we_o}, 32'd0);
        chk("redirect_at_strobe", {31'd0, redirect_o}, 32'd1);
        chk("trap_pc", trap_pc_o, e.pc);
        if (!e.is_mret) begin
          chk("mepc", csr_mepc_o, e.mepc);
          chk("mcause", csr_mcause_o, e.mcause);
          chk("mtval", csr_mtval_o, e.mtval);
        end
      end
      if (csr_mret_we_o) n_mret++;
      if (csr_trap_we_o) n_trap++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_redir;
    rst_i = 1'b1;
    {irq_meip_i, irq_mtip_i, irq_msip_i} = 3'b000;
    mstatus_mie_i = 1'b0; mstatus_mpie_i = 1'b0; mie_i = 3'b000;
    mtvec_i = 32'h200; mepc_i = 32'h0; pc_i = 32'h0; exc_tval_i = 32'h0;
    commit_valid_i = 1'b0; exc_valid_i = 1'b0; exc_cause_i = 4'd0;
    mret_i = 1'b0; redirect_ack_i = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
    chk("rst_trap_pc", trap_pc_o, RstPc);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_mip", {29'd0, mip_o}, 32'd0);
    chk("rst_mcause", csr_mcause_o, 32'd0);
    tick();
    rst_i = 1'b0;

    // Illegal instruction, delayed ack
    commit_valid_i = 1'b1; exc_valid_i = 1'b1; exc_cause_i = 4'd2;
    pc_i = 32'h100; exc_tval_i = 32'hDEAD_BEEF; mtvec_i = 32'h200;
    push(1'b0, 32'h200, 32'h100, 32'h2, 32'hDEAD_BEEF);
    tick();
    commit_valid_i = 1'b0; exc_valid_i = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("t1_busy_held", {31'd0, busy_o}, 32'd1);
    chk("t1_redirect_held", {31'd0, redirect_o}, 32'd1);
    chk("t1_pc_held", trap_pc_o, 32'h200);
    chk("t1_one_strobe", n_trap, 1);
    redirect_ack_i = 1'b1;
    tick();
    redirect_ack_i = 1'b0;
    wait_idle("t1_idle", 10);

    // Vectored timer interrupt through the synchronizer, ack in the TRAP cycle
    mtvec_i = 32'h1001; mstatus_mie_i = 1'b1; mie_i = 3'b010;
    irq_mtip_i = 1'b1;
    tick();
    @(negedge clk);
    chk("t2_mip_1cyc", {29'd0, mip_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("t2_mip_2cyc", {29'd0, mip_o}, 32'h2);
    commit_valid_i = 1'b1; pc_i = 32'h40; redirect_ack_i = 1'b1;
    push(1'b0, 32'h101C, 32'h40, 32'h8000_0007, 32'h0);
    tick();
    commit_valid_i = 1'b0;
    tick();
    @(negedge clk);
    chk("t2_direct_idle", {31'd0, busy_o}, 32'd0);
    redirect_ack_i = 1'b0; irq_mtip_i = 1'b0; mstatus_mie_i = 1'b0;
    repeat (3) tick();

    // Exception beats MEI+MTI; afterwards MIE=0 masks the still-pending MEI
    mstatus_mie_i = 1'b1; mie_i = 3'b111; irq_meip_i = 1'b1; irq_mtip_i = 1'b1;
    repeat (3) tick();
    commit_valid_i = 1'b1; exc_valid_i = 1'b1; exc_cause_i = 4'd11;
    pc_i = 32'h500; exc_tval_i = 32'h0;
    push(1'b0, 32'h1000, 32'h500, 32'hB, 32'h0);
    tick();
    commit_valid_i = 1'b0; exc_valid_i = 1'b0;
    mstatus_mie_i = 1'b0; redirect_ack_i = 1'b1;
    tick();
    redirect_ack_i = 1'b0;
    commit_valid_i = 1'b1; pc_i = 32'h504;
    tick();
    commit_valid_i = 1'b0;
    @(negedge clk);
    chk("t3_masked_busy", {31'd0, busy_o}, 32'd0);
    chk("t3_trap_count", n_trap, 3);
    irq_mtip_i = 1'b0;

    // MEI and MSI together, vectored
    mstatus_mie_i = 1'b1; irq_msip_i = 1'b1;
    repeat (3) tick();
    commit_valid_i = 1'b1; pc_i = 32'h600; redirect_ack_i = 1'b1;
    push(1'b0, 32'h102C, 32'h600, 32'h8000_000B, 32'h0);
    tick();
    commit_valid_i = 1'b0;
    mstatus_mie_i = 1'b0; irq_meip_i = 1'b0; irq_msip_i = 1'b0;
    tick();
    redirect_ack_i = 1'b0;
    repeat (3) tick();

    // Exception overrides MRET in the same commit, direct mtvec
    mtvec_i = 32'h200;
    commit_valid_i = 1'b1; exc_valid_i = 1'b1; mret_i = 1'b1; exc_cause_i = 4'd4;
    pc_i = 32'h700; exc_tval_i = 32'h1234; redirect_ack_i = 1'b1;
    push(1'b0, 32'h200, 32'h700, 32'h4, 32'h1234);
    tick();
    commit_valid_i = 1'b0; exc_valid_i = 1'b0; mret_i = 1'b0;
    tick();
    redirect_ack_i = 1'b0;
    chk("t5_no_mret", n_mret, 0);

    // MRET with ack three cycles late
    mepc_i = 32'h301;
    commit_valid_i = 1'b1; mret_i = 1'b1;
    push(1'b1, 32'h300, 32'h0, 32'h0, 32'h0);
    tick();
    commit_valid_i = 1'b0; mret_i = 1'b0;
    n_redir = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) redirect_ack_i = 1'b1;
      @(negedge clk);
      if (redirect_o) n_redir++;
      chk("t6_pc_hold", trap_pc_o, 32'h300);
      tick();
    end
    redirect_ack_i = 1'b0;
    @(negedge clk);
    chk("t6_redirect_cycles", n_redir, 4);
    chk("t6_redirect_drop", {31'd0, redirect_o}, 32'd0);
    chk("t6_mret_once", n_mret, 1);

    // Reset while waiting for ack
    commit_valid_i = 1'b1; exc_valid_i = 1'b1; exc_cause_i = 4'd5;
    pc_i = 32'h800; exc_tval_i = 32'h44;
    push(1'b0, 32'h200, 32'h800, 32'h5, 32'h44);
    tick();
    commit_valid_i = 1'b0; exc_valid_i = 1'b0;
    tick();
    @(negedge clk);
    chk("t7_in_wait_ack", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    @(negedge clk);
    chk("t7_rst_redirect", {31'd0, redirect_o}, 32'd0);
    chk("t7_rst_pc", trap_pc_o, RstPc);
    rst_i = 1'b0;
    @(negedge clk);
    chk("t7_post_busy", {31'd0, busy_o}, 32'd0);
    chk("t7_post_redirect", {31'd0, redirect_o}, 32'd0);
    chk("t7_post_pc", trap_pc_o, RstPc);
    chk("t7_post_mepc", csr_mepc_o, 32'd0);
    chk("t7_trap_total", n_trap, 6);

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
